// File: rtl/list_stat_collector.sv
// list_stat_collector: segments a pointer stream into lists and queues per-list
// records (head, length, XOR checksum, repeated-node flag) for a valid/ready consumer.
`default_nettype none

module list_stat_collector #(
  parameter int N     = 16,
  parameter int WIDTH = $clog2(N),
  parameter int LEN_W = WIDTH + 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_ptr,
  input  logic             in_vld,
  input  logic             in_last,
  output logic             in_rdy,
  output logic [WIDTH-1:0] res_head,
  output logic [LEN_W-1:0] res_len,
  output logic [WIDTH-1:0] res_xor,
  output logic             res_dup,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = '1;

  // accumulator for the list currently being received
  logic             active;
  logic [WIDTH-1:0] head;
  logic [LEN_W-1:0] len;
  logic [WIDTH-1:0] xr;
  logic [N-1:0]     visited;
  logic             dup;
  logic             err_q;

  // result FIFO
  logic [WIDTH-1:0] head_mem [DEPTH];
  logic [LEN_W-1:0] len_mem  [DEPTH];
  logic [WIDTH-1:0] xor_mem  [DEPTH];
  logic             dup_mem  [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             take;
  logic             take_null;
  logic             accept;
  logic             close_null;
  logic             push;
  logic             pop;
  logic             sat;
  logic [N-1:0]     onehot;
  logic [WIDTH-1:0] head_nx;
  logic [LEN_W-1:0] len_nx;
  logic [WIDTH-1:0] xr_nx;
  logic             dup_nx;
  logic [N-1:0]     visited_nx;
  logic [WIDTH-1:0] rec_head;
  logic [LEN_W-1:0] rec_len;
  logic [WIDTH-1:0] rec_xor;
  logic             rec_dup;

  assign in_rdy  = (count != CW'(DEPTH));
  assign res_vld = (count != '0);

  assign take       = in_vld & in_rdy;
  assign take_null  = take & (in_ptr == '0);
  assign accept     = take & (in_ptr != '0);
  assign close_null = take_null & in_last & active;
  assign push       = (accept & in_last) | close_null;
  assign pop        = res_vld & res_rdy;
  assign sat        = accept & active & (len == LEN_MAX);

  assign onehot     = {{(N-1){1'b0}}, 1'b1} << in_ptr;
  assign head_nx    = active ? head : in_ptr;
  assign len_nx     = !active ? LEN_W'(1) : ((len == LEN_MAX) ? len : len + LEN_W'(1));
  assign xr_nx      = active ? (xr ^ in_ptr) : in_ptr;
  assign dup_nx     = active & (dup | visited[in_ptr]);
  assign visited_nx = active ? (visited | onehot) : onehot;

  // a null-terminated list closes on the accumulator as it stands
  assign rec_head = accept ? head_nx : head;
  assign rec_len  = accept ? len_nx  : len;
  assign rec_xor  = accept ? xr_nx   : xr;
  assign rec_dup  = accept ? dup_nx  : dup;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      head    <= '0;
      len     <= '0;
      xr      <= '0;
      visited <= '0;
      dup     <= 1'b0;
      err_q   <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
    end else begin
      if (take_null || sat)
        err_q <= 1'b1;
      if (push) begin
        active  <= 1'b0;
        head    <= '0;
        len     <= '0;
        xr      <= '0;
        visited <= '0;
        dup     <= 1'b0;
      end else if (accept) begin
        active  <= 1'b1;
        head    <= head_nx;
        len     <= len_nx;
        xr      <= xr_nx;
        visited <= visited_nx;
        dup     <= dup_nx;
      end
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (!push && pop)
        count <= count - CW'(1);
    end
  end

  // storage needs no reset; outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      head_mem[wr_ptr] <= rec_head;
      len_mem[wr_ptr]  <= rec_len;
      xor_mem[wr_ptr]  <= rec_xor;
      dup_mem[wr_ptr]  <= rec_dup;
    end
  end

  assign res_head = res_vld ? head_mem[rd_ptr] : '0;
  assign res_len  = res_vld ? len_mem[rd_ptr]  : '0;
  assign res_xor  = res_vld ? xor_mem[rd_ptr]  : '0;
  assign res_dup  = res_vld & dup_mem[rd_ptr];
  assign err      = err_q;

endmodule

`default_nettype wire
